// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths and types for the instruction-fetch stage.
//   `WORD : instruction width (default 32)
//   `ADDR : word-address width (default 16)
// The `ifndef guards let any file in the slice be compiled first.
// Optional feature macro used by the stage: IFETCH_HALT_EN.
`ifndef WORD
`define WORD 32
`endif
`ifndef ADDR
`define ADDR 16
`endif

package ifetch_pkg;
  localparam int WORD_W = `WORD;
  localparam int ADDR_W = `ADDR;

  localparam logic [ADDR_W-1:0] RESET_ADDR_DEF = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE       = ADDR_W'(1);

  // next-PC source select
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_BR   = 2'd2
  } pc_sel_e;

  // in-flight memory read
  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] addr;
  } req_t;

  // registered output presented to decode
  typedef struct packed {
    logic              v;
    logic [WORD_W-1:0] inst;
    logic [ADDR_W-1:0] origaddr;
  } out_t;
endpackage

// File: rtl/ifetch_pc.sv
// ifetch_pc: program counter register and next-PC mux.
// Ports:
//   clk, rst     : clock, async active-high reset (pc -> RESET_ADDR)
//   sel_i        : PC_HOLD / PC_INC / PC_BR
//   br_addr_i    : redirect target used when sel_i == PC_BR
//   pc_o         : current fetch address
// Increment wraps modulo 2^`ADDR.
`ifndef WORD
`define WORD 32
`endif
`ifndef ADDR
`define ADDR 16
`endif

module ifetch_pc
  import ifetch_pkg::*;
#(
  parameter logic [`ADDR-1:0] RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  pc_sel_e          sel_i,
  input  logic [`ADDR-1:0] br_addr_i,
  output logic [`ADDR-1:0] pc_o
);

  logic [`ADDR-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    case (sel_i)
      PC_INC:  pc_d = pc_q + ADDR_ONE;
      PC_BR:   pc_d = br_addr_i;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_ADDR;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction-fetch stage feeding decode.
// Ports:
//   clk, rst              : clock, async active-high reset
//   imem_rd_o/imem_addr_o : read request to a 1-cycle synchronous imem
//   imem_data_i           : read data, valid the cycle after a read, held otherwise
//   br_taken_i/br_addr_i  : redirect from execute (beats stall)
//   stall_i               : decode stall, only honoured while v_o=1
//   v_o/inst_o/origaddr_o : fetched instruction and its address
//   halt_i                : only with `define IFETCH_HALT_EN; stops new requests,
//                           lets the in-flight one drain
`ifndef WORD
`define WORD 32
`endif
`ifndef ADDR
`define ADDR 16
`endif

module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [`ADDR-1:0] RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_rd_o,
  output logic [`ADDR-1:0] imem_addr_o,
  input  logic [`WORD-1:0] imem_data_i,
  input  logic             br_taken_i,
  input  logic [`ADDR-1:0] br_addr_i,
  input  logic             stall_i,
`ifdef IFETCH_HALT_EN
  input  logic             halt_i,
`endif
  output logic             v_o,
  output logic [`WORD-1:0] inst_o,
  output logic [`ADDR-1:0] origaddr_o
);

  logic             advance, issue, halt;
  logic [`ADDR-1:0] pc;
  pc_sel_e          pc_sel;
  req_t             req_d, req_q;
  out_t             out_d, out_q;

`ifdef IFETCH_HALT_EN
  assign halt = halt_i;
`else
  assign halt = 1'b0;
`endif

  ifetch_pc #(.RESET_ADDR(RESET_ADDR)) u_pc (
    .clk       (clk),
    .rst       (rst),
    .sel_i     (pc_sel),
    .br_addr_i (br_addr_i),
    .pc_o      (pc)
  );

  always_comb begin
    // a bubble in the output register never blocks the pipe
    advance = ~(out_q.v & stall_i);
    issue   = advance & ~br_taken_i & ~halt & ~rst;
    pc_sel  = br_taken_i ? PC_BR : (issue ? PC_INC : PC_HOLD);
    req_d   = req_q;
    out_d   = out_q;
    if (br_taken_i) begin
      req_d.v = 1'b0;
      out_d.v = 1'b0;
    end else if (advance) begin
      // while halted, req_d.v drops so the last request drains exactly once
      req_d.v = issue;
      if (issue) req_d.addr = pc;
      out_d.v        = req_q.v;
      out_d.inst     = imem_data_i;
      out_d.origaddr = req_q.addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
      out_q <= '0;
    end else begin
      req_q <= req_d;
      out_q <= out_d;
    end
  end

  assign imem_rd_o   = issue;
  assign imem_addr_o = pc;
  assign v_o         = out_q.v;
  assign inst_o      = out_q.inst;
  assign origaddr_o  = out_q.origaddr;

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: directed vector table, async reset sequence,
// randomized run against a delivered-stream model, halt sequence when
// IFETCH_HALT_EN is defined.
`ifndef WORD
`define WORD 32
`endif
`ifndef ADDR
`define ADDR 16
`endif

module tb_ifetch;
  localparam int AW = `ADDR;
  localparam int WW = `WORD;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_rd_o;
  logic [AW-1:0] imem_addr_o;
  logic [WW-1:0] imem_data_i = '0;
  logic          br_taken_i;
  logic [AW-1:0] br_addr_i;
  logic          stall_i;
  logic          halt_i;
  logic          v_o;
  logic [WW-1:0] inst_o;
  logic [AW-1:0] origaddr_o;

  int checks = 0;
  int errors = 0;

  ifetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_rd_o   (imem_rd_o),
    .imem_addr_o (imem_addr_o),
    .imem_data_i (imem_data_i),
    .br_taken_i  (br_taken_i),
    .br_addr_i   (br_addr_i),
    .stall_i     (stall_i),
`ifdef IFETCH_HALT_EN
    .halt_i      (halt_i),
`endif
    .v_o         (v_o),
    .inst_o      (inst_o),
    .origaddr_o  (origaddr_o)
  );

  always #5 clk = ~clk;

  // memory contents: word[i] = 0x1000 + i
  function automatic logic [WW-1:0] memf(input logic [AW-1:0] a);
    return WW'(32'h1000) + WW'(a);
  endfunction

  // synchronous imem: data appears the cycle after a read, held otherwise
  always @(posedge clk) if (imem_rd_o) imem_data_i <= memf(imem_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          stall;
    logic          br;
    logic [AW-1:0] br_addr;
    logic          exp_v;
    logic [AW-1:0] exp_o;
    logic          exp_rd;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input logic s, input logic b, input logic [AW-1:0] ba,
                              input logic v, input logic [AW-1:0] o, input logic rd);
    vec_t r;
    r.stall = s; r.br = b; r.br_addr = ba; r.exp_v = v; r.exp_o = o; r.exp_rd = rd;
    return r;
  endfunction

  // model state for the random run
  int            since;
  logic [AW-1:0] target;
  logic [AW-1:0] delivered;
  logic [AW-1:0] ones;

  initial begin
    logic          exp_v;
    logic [AW-1:0] exp_a;
    logic [AW-1:0] a;
    int            cnt;
    logic [AW-1:0] seen;

    ones = '1;
    // row 0 = first cycle after reset release
    tbl[0]  = mk(0, 0, 0,       0, 0,       1);
    tbl[1]  = mk(0, 0, 0,       0, 0,       1);
    tbl[2]  = mk(0, 0, 0,       1, 0,       1);
    tbl[3]  = mk(0, 0, 0,       1, 1,       1);
    tbl[4]  = mk(0, 0, 0,       1, 2,       1);
    tbl[5]  = mk(0, 0, 0,       1, 3,       1);
    tbl[6]  = mk(0, 0, 0,       1, 4,       1);
    tbl[7]  = mk(1, 0, 0,       1, 5,       0);
    tbl[8]  = mk(1, 0, 0,       1, 5,       0);
    tbl[9]  = mk(1, 0, 0,       1, 5,       0);
    tbl[10] = mk(0, 0, 0,       1, 5,       1);
    tbl[11] = mk(0, 0, 0,       1, 6,       1);
    tbl[12] = mk(0, 0, 0,       1, 7,       1);
    tbl[13] = mk(0, 1, 'h40,    1, 8,       0);
    tbl[14] = mk(0, 0, 0,       0, 0,       1);
    tbl[15] = mk(0, 0, 0,       0, 0,       1);
    tbl[16] = mk(0, 0, 0,       1, 'h40,    1);
    tbl[17] = mk(0, 0, 0,       1, 'h41,    1);
    tbl[18] = mk(1, 1, 'h80,    1, 'h42,    0);
    tbl[19] = mk(0, 0, 0,       0, 0,       1);
    tbl[20] = mk(0, 0, 0,       0, 0,       1);
    tbl[21] = mk(0, 0, 0,       1, 'h80,    1);
    tbl[22] = mk(0, 1, ones,    1, 'h81,    0);
    tbl[23] = mk(0, 0, 0,       0, 0,       1);
    tbl[24] = mk(0, 0, 0,       0, 0,       1);
    tbl[25] = mk(0, 0, 0,       1, ones,    1);
    tbl[26] = mk(0, 0, 0,       1, 0,       1);
    tbl[27] = mk(0, 0, 0,       1, 1,       1);

    rst = 1'b1; br_taken_i = 0; br_addr_i = '0; stall_i = 0; halt_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset v_o", v_o, 0);
    chk("reset imem_rd_o", imem_rd_o, 0);
    chk("reset inst_o", inst_o, 0);
    chk("reset origaddr_o", origaddr_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 28; i++) begin
      stall_i = tbl[i].stall; br_taken_i = tbl[i].br; br_addr_i = tbl[i].br_addr;
      @(negedge clk);
      chk($sformatf("tbl%0d v_o", i), v_o, tbl[i].exp_v);
      chk($sformatf("tbl%0d imem_rd_o", i), imem_rd_o, tbl[i].exp_rd);
      if (tbl[i].exp_v) begin
        chk($sformatf("tbl%0d origaddr_o", i), origaddr_o, tbl[i].exp_o);
        chk($sformatf("tbl%0d inst_o", i), inst_o, memf(tbl[i].exp_o));
      end
      @(posedge clk); #1;
    end
    stall_i = 0; br_taken_i = 0;
    repeat (3) @(posedge clk);

    // async reset mid-stream, with a redirect that must be ignored
    #2;
    rst = 1'b1; br_taken_i = 1'b1; br_addr_i = 'h1234;
    #1;
    chk("async rst v_o", v_o, 0);
    chk("async rst imem_rd_o", imem_rd_o, 0);
    @(posedge clk); #1;
    rst = 1'b0; br_taken_i = 1'b0;
    @(negedge clk); chk("post-rst C0 v_o", v_o, 0);
    @(negedge clk); chk("post-rst C1 v_o", v_o, 0);
    @(negedge clk);
    chk("post-rst C2 v_o", v_o, 1);
    chk("post-rst C2 origaddr_o", origaddr_o, 0);
    chk("post-rst C2 inst_o", inst_o, memf(0));
    @(posedge clk); #1;

    // random run vs. delivered-stream model:
    // v_o is due two edges after the last flush; the n-th delivered word
    // since a flush comes from target+n.
    rst = 1'b1; since = 0; target = '0; delivered = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      exp_v = !rst && since >= 2;
      exp_a = target + delivered;
      chk("rand v_o", v_o, exp_v);
      chk("rand imem_rd_o", imem_rd_o, !rst && !br_taken_i && !(exp_v && stall_i));
      if (exp_v) begin
        chk("rand origaddr_o", origaddr_o, exp_a);
        chk("rand inst_o", inst_o, memf(exp_a));
      end
      @(posedge clk);
      if (rst) begin
        since = 0; target = '0; delivered = '0;
      end else if (br_taken_i) begin
        since = 0; target = br_addr_i; delivered = '0;
      end else begin
        if (exp_v && !stall_i) delivered = delivered + 1'b1;
        if (since < 2) since++;
      end
      #1;
      rst        = ($urandom_range(0, 199) == 0);
      stall_i    = ($urandom_range(0, 9) < 3);
      br_taken_i = ($urandom_range(0, 24) == 0);
      br_addr_i  = ($urandom_range(0, 3) == 0) ? ones - AW'($urandom_range(0, 3))
                                               : AW'($urandom);
    end
    rst = 0; stall_i = 0; br_taken_i = 0;
    repeat (4) @(posedge clk); #1;

`ifdef IFETCH_HALT_EN
    halt_i = 1'b1;
    @(negedge clk);
    a = origaddr_o;
    chk("halt entry v_o", v_o, 1);
    chk("halt imem_rd_o", imem_rd_o, 0);
    cnt = 0; seen = '0;
    repeat (4) begin
      @(negedge clk);
      if (v_o) begin cnt++; seen = origaddr_o; end
    end
    chk("halt drain count", cnt, 1);
    chk("halt drain addr", seen, a + 1'b1);
    @(posedge clk); #1;
    halt_i = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6 && cnt == 0; k++) begin
      @(negedge clk);
      if (v_o) begin cnt = 1; seen = origaddr_o; end
    end
    chk("halt resume seen", cnt, 1);
    chk("halt resume addr", seen, a + AW'(2));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
